// File: rtl/rgb_seq_monitor.sv
// Receive-side checker for the RGB traffic-light phase sequence on the LED pins.
// Define RGB_MON_STATS_EN to build the dwell_last capture register (else dwell_last is 0).
module rgb_seq_monitor #(
    parameter int unsigned PHASE_CYCLES  = 100_000_000,
    parameter int unsigned TOL_CYCLES    = 1_000_000,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             b_in,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             seq_err,
    output logic             time_err,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] dwell_last
);
    localparam int unsigned      STAB_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_MIN   = CNT_W'(PHASE_CYCLES - TOL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_MAX   = CNT_W'(PHASE_CYCLES + TOL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_STALL = CNT_W'(PHASE_CYCLES + TOL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_ONE   = CNT_W'(1);
    localparam logic [STAB_W:0]  STAB_REQ    = (STAB_W + 1)'(STABLE_CYCLES);
    localparam logic [STAB_W:0]  RUN_ONE     = (STAB_W + 1)'(1);

    typedef enum logic [1:0] {SEARCH, SYNC, TRACK} state_t;
    state_t state;

    logic [2:0]       sync1, sync2, cand, acc_code;
    logic [STAB_W-1:0] stab;
    logic [STAB_W:0]  run_len;
    logic [CNT_W-1:0] dwell;
    logic [1:0]       code_idx;
    logic             code_legal, accept, in_order, in_window, stall, err_event;

    always_comb begin
        code_legal = 1'b1;
        code_idx   = 2'd0;
        case (sync2)
            3'b100:  code_idx = 2'd0;
            3'b110:  code_idx = 2'd1;
            3'b010:  code_idx = 2'd2;
            3'b111:  code_idx = 2'd3;
            default: code_legal = 1'b0;
        endcase
        // run_len includes the current synchronised sample
        run_len   = (sync2 == cand) ? ({1'b0, stab} + RUN_ONE) : RUN_ONE;
        accept    = (run_len >= STAB_REQ) && (sync2 != acc_code);
        in_order  = (code_idx == phase + 2'd1);
        in_window = (dwell >= DWELL_MIN) && (dwell <= DWELL_MAX);
        stall     = (state == TRACK) && (dwell == DWELL_STALL);
        err_event = accept ? (!code_legal || ((state == TRACK) && !(in_order && in_window)))
                           : stall;
    end

    // Synchroniser, deglitch filter and dwell counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            stab     <= '0;
            acc_code <= '0;
            dwell    <= '0;
        end else begin
            sync1 <= {r_in, g_in, b_in};
            sync2 <= sync1;
            cand  <= sync2;
            stab  <= (run_len >= STAB_REQ) ? STAB_REQ[STAB_W-1:0] : run_len[STAB_W-1:0];
            if (accept) begin
                acc_code <= sync2;
                dwell    <= DWELL_ONE;
            end else if (dwell != '1) begin
                dwell <= dwell + DWELL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
            time_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            seq_err  <= 1'b0;
            time_err <= 1'b0;
            if (err_event && (err_count != '1))
                err_count <= err_count + 8'd1;
            if (accept) begin
                if (!code_legal) begin
                    seq_err     <= 1'b1;
                    phase_valid <= 1'b0;
                    locked      <= 1'b0;
                    state       <= SEARCH;
                end else begin
                    phase       <= code_idx;
                    phase_valid <= 1'b1;
                    case (state)
                        SEARCH: state <= SYNC;
                        SYNC: begin
                            if (in_order) begin
                                state  <= TRACK;
                                locked <= 1'b1;
                            end
                        end
                        TRACK: begin
                            if (!in_order) begin
                                seq_err <= 1'b1;
                                state   <= SYNC;
                                locked  <= 1'b0;
                            end else if (!in_window) begin
                                time_err <= 1'b1;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end else if (stall) begin
                time_err <= 1'b1;
                state    <= SYNC;
                locked   <= 1'b0;
            end
        end
    end

`ifdef RGB_MON_STATS_EN
    logic [CNT_W-1:0] dwell_cap;

    always_ff @(posedge clk) begin
        if (rst)
            dwell_cap <= '0;
        else if (accept && (state != SEARCH))
            dwell_cap <= dwell;
    end

    assign dwell_last = dwell_cap;
`else
    assign dwell_last = '0;
`endif

endmodule

// File: doc/rgb_seq_monitor.md
Name: rgb_seq_monitor

Overview:
Receive-side checker for the RGB traffic-light sequence driven onto the LED pins. It samples the three colour lines, synchronises and deglitches them, and decodes the phase. It verifies that phases advance in order (0->1->2->3->0) with the configured dwell time, and reports the current phase, lock status and errors. It sits in the same clock domain as the sequencer, on a loop-back or on a board-level observation path.

Parameters:
PHASE_CYCLES, 100_000_000, nominal dwell per phase in clk cycles
TOL_CYCLES, 1_000_000, allowed +/- deviation from PHASE_CYCLES
STABLE_CYCLES, 16, consecutive identical samples required to accept a new code (>=1)
CNT_W, 27, width of the dwell counter; must hold PHASE_CYCLES+TOL_CYCLES+1

Ports:
clk  input  1  system clock (100 MHz nominal)
rst  input  1  synchronous, active-high reset
r_in  input  1  red line, asynchronous to clk
g_in  input  1  green line, asynchronous to clk
b_in  input  1  blue line, asynchronous to clk
phase  output  2  last accepted valid phase index
phase_valid  output  1  accepted code is one of the four legal codes
locked  output  1  in TRACK state
seq_err  output  1  one-cycle pulse on illegal code or out-of-order transition
time_err  output  1  one-cycle pulse on dwell out of tolerance or stall
err_count  output  8  saturating total of seq_err and time_err events
dwell_last  output  CNT_W  last completed dwell (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: phase=0, phase_valid=0, locked=0, seq_err=0, time_err=0, err_count=0, dwell_last=0. Synchroniser flops, filter and counters are cleared. State=SEARCH.
- Code map {r,g,b}: 100->phase 0, 110->phase 1, 010->phase 2, 111->phase 3. All other codes are illegal.
- Synchroniser: 2-FF per line.
- Filter: candidate register plus stability counter. A new code is accepted when the synchronised value has been equal to the candidate for STABLE_CYCLES consecutive cycles and differs from the accepted code.
- Fixed latency from pin change to accept: 2+STABLE_CYCLES cycles. A glitch shorter than STABLE_CYCLES is never accepted.
- Dwell counter: increments every cycle and saturates at all-ones. It is cleared to 1 on the cycle of an accept, so the measured dwell equals the input dwell.
- State SEARCH: the first accepted legal code loads phase, sets phase_valid and goes to SYNC. The dwell is not checked.
- State SYNC: the first accept of a legal code equal to phase+1 (mod 4) goes to TRACK and sets locked. This dwell is not checked because it is partial.
- State TRACK, on each accept:
  - legal code equal to phase+1 with dwell in [PHASE_CYCLES-TOL_CYCLES, PHASE_CYCLES+TOL_CYCLES]: update phase, no error.
  - legal in-order code with dwell outside that window: time_err pulse, update phase, stay in TRACK.
  - legal out-of-order code: seq_err pulse, update phase, go to SYNC, locked=0.
- Illegal accepted code in any state: seq_err pulse, phase_valid=0, phase holds, go to SEARCH, locked=0.
- Stall in TRACK: when dwell reaches PHASE_CYCLES+TOL_CYCLES+1 without an accept, time_err pulses once, state goes to SYNC and locked=0.
- err_count: +1 per cycle in which seq_err or time_err is high; saturates at 255. The two are never asserted together.
- All outputs are registered, and pulses are asserted the cycle after the accept.
- rst asserted mid-phase returns everything to reset values on the next edge. Monitoring restarts from SEARCH.

Optional Feature:
Macro RGB_MON_STATS_EN.
- Defined: dwell_last captures the dwell counter value at every accept in TRACK or SYNC state, and holds it until the next accept.
- Undefined: dwell_last is tied to 0 and its capture register is not built. All other behaviour is identical.

Test Plan:
(Sim parameters: PHASE_CYCLES=100, TOL_CYCLES=5, STABLE_CYCLES=4, CNT_W=8.)
- Ideal sequence 100,110,010,111,100 with 100 cycles each -> locked rises after the first transition. phase steps 0,1,2,3,0; no errors; err_count=0; dwell_last=100 (macro on).
- While locked, phase 1 held for 110 cycles -> one time_err pulse at the accept; phase=2; locked stays 1; err_count=1.
- While locked, jump from phase 1 (110) to phase 3 (111) -> seq_err pulse; locked=0; phase=3. The next in-order transition re-locks.
- While locked, a 3-cycle glitch to 000 mid-phase -> no accept, no error, dwell measurement unaffected.
- While locked, hold phase 2 indefinitely -> time_err exactly once, 106 cycles after its accept; locked=0; no further pulses.
- Inject 001 for 10 cycles -> seq_err pulse; phase_valid=0; state SEARCH. Then 300 error events -> err_count saturates at 255. Assert rst mid-run -> all outputs return to 0 on the next cycle.
